// File: rtl/lfsr_rr_server.sv
// Round-robin server that hands out words from one shared 8-bit Fibonacci LFSR.
// Each grant is preceded by STEPS LFSR shifts so successive consumers see decorrelated values.
module lfsr_rr_server #(
    parameter int                DATA_LEN = 8,
    parameter int                NUM_REQ  = 4,
    parameter int                STEPS    = 4,
    parameter logic [DATA_LEN-1:0] SEED   = 8'h01
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                seed_load,
    input  logic [DATA_LEN-1:0] seed,
    input  logic [NUM_REQ-1:0]  req,
    output logic                rsp_valid,
    output logic [NUM_REQ-1:0]  rsp_gnt,
    output logic [DATA_LEN-1:0] rsp_data,
    output logic                busy,
    output logic [DATA_LEN-1:0] lfsr_q
);

    localparam int          IW      = $clog2(NUM_REQ);
    localparam logic [3:0]  STEPS_C = 4'(STEPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_GRANT
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_LEN-1:0] lfsr_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       win_q, win_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]  rsp_gnt_q, rsp_gnt_d;
    logic [DATA_LEN-1:0] rsp_data_q, rsp_data_d;
    logic                busy_q, busy_d;

    logic [DATA_LEN-1:0] lfsr_step;
    logic [DATA_LEN-1:0] seed_safe;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [IW-1:0]       pick_idx;
    logic [IW-1:0]       win_inc;
    int                  scan_idx;

    // Taps x^8+x^6+x^5+x^4+1 in right-shift form.
    assign lfsr_step = {lfsr_q[4] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0], lfsr_q[DATA_LEN-1:1]};
    assign seed_safe = (seed == '0) ? {seed[DATA_LEN-1:1], 1'b1} : seed;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_q == IW'(gi));
        end
    endgenerate

    assign win_inc = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        pick_idx = '0;
        scan_idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (req[scan_idx[IW-1:0]]) begin
                pick_idx = scan_idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_gnt_d   = '0;
        rsp_data_d  = rsp_data_q;

        if (seed_load) begin
            // A reload abandons any transaction in flight without granting it.
            lfsr_d  = seed_safe;
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        win_d   = pick_idx;
                        cnt_d   = STEPS_C;
                        state_d = S_STEP;
                    end
                end
                S_STEP: begin
                    lfsr_d = lfsr_step;
                    cnt_d  = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_GRANT;
                    end
                end
                S_GRANT: begin
                    rsp_valid_d = 1'b1;
                    rsp_gnt_d   = win_onehot;
                    rsp_data_d  = lfsr_q;
                    rr_ptr_d    = win_inc;
                    state_d     = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_STEP) || (state_d == S_GRANT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_gnt_q   <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_gnt_q   <= rsp_gnt_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_gnt   = rsp_gnt_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lfsr_rr_server.sv
// Directed bench for lfsr_rr_server: latency, data sequence, fairness, seed reload and reset abort.
module tb_lfsr_rr_server;

    logic       clk;
    logic       rst_n;
    logic       seed_load;
    logic [7:0] seed;
    logic [3:0] req;
    logic       rsp_valid;
    logic [3:0] rsp_gnt;
    logic [7:0] rsp_data;
    logic       busy;
    logic [7:0] lfsr_q;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    lfsr_rr_server #(
        .DATA_LEN (8),
        .NUM_REQ  (4),
        .STEPS    (4),
        .SEED     (8'h01)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .req       (req),
        .rsp_valid (rsp_valid),
        .rsp_gnt   (rsp_gnt),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .lfsr_q    (lfsr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated request: pulse req for the arbitration edge, then wait for the response.
    task automatic run_txn(input string tag, input logic [3:0] r,
                           input logic [3:0] exp_gnt, input logic [7:0] exp_data);
        int cnt;
        int bcnt;
        req = r;
        @(negedge clk);
        req  = '0;
        cnt  = 0;
        bcnt = 0;
        while (!rsp_valid && cnt < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'd5);
        check({tag, "_gnt"}, 32'(rsp_gnt), 32'(exp_gnt));
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'd5);
        @(negedge clk);
        check({tag, "_valid_pulse"}, 32'(rsp_valid), 32'd0);
        check({tag, "_gnt_clear"}, 32'(rsp_gnt), 32'd0);
        check({tag, "_data_hold"}, 32'(rsp_data), 32'(exp_data));
        $display("txn %s: req=%b gnt=%b data=%h", tag, r, exp_gnt, exp_data);
    endtask

    initial begin
        int cnt;
        int last;
        int vcnt;

        rst_n     = 1'b0;
        seed_load = 1'b0;
        seed      = 8'h00;
        req       = 4'b0000;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_gnt",   32'(rsp_gnt),   32'd0);
        check("rst_data",  32'(rsp_data),  32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_lfsr",  32'(lfsr_q),    32'h01);
        rst_n = 1'b1;
        @(negedge clk);

        // 01 -> 80 -> 40 -> 20 -> 10, then 10 -> 88 -> C4 -> E2 -> 71.
        run_txn("t1", 4'b0001, 4'b0001, 8'h10);
        run_txn("t2", 4'b0100, 4'b0100, 8'h71);

        // Fresh reset so the pointer starts at requester 0 for the fairness run.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req  = 4'b1111;
        last = 0;
        for (int g = 0; g < 8; g++) begin
            cnt = 0;
            while (!rsp_valid && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            check("t3_timeout", 32'(cnt < 20), 32'd1);
            check("t3_gnt", 32'(rsp_gnt), 32'(4'b0001 << (g % 4)));
            if (g > 0) check("t3_spacing", 32'(cyc - last), 32'd6);
            $display("txn t3 grant %0d: gnt=%b data=%h", g, rsp_gnt, rsp_data);
            last = cyc;
            if (g == 7) req = 4'b0000;
            @(negedge clk);
        end

        // Zero seed is sanitised to 01.
        seed_load = 1'b1;
        seed      = 8'h00;
        @(negedge clk);
        seed_load = 1'b0;
        check("t4_lfsr", 32'(lfsr_q), 32'h01);
        check("t4_busy", 32'(busy), 32'd0);
        $display("txn t4: seed load 00 -> lfsr=%h", lfsr_q);
        run_txn("t4b", 4'b0010, 4'b0010, 8'h10);

        // Abort on the second STEP cycle; pointer stays at 2 so requester 2 wins again.
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        check("t5_lfsr_step1", 32'(lfsr_q), 32'h88);
        seed_load = 1'b1;
        seed      = 8'hA5;
        @(negedge clk);
        seed_load = 1'b0;
        check("t5_lfsr", 32'(lfsr_q), 32'hA5);
        check("t5_busy", 32'(busy), 32'd0);
        vcnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid) vcnt++;
            @(negedge clk);
        end
        check("t5_no_valid", 32'(vcnt), 32'd0);
        check("t5_lfsr_hold", 32'(lfsr_q), 32'hA5);
        $display("txn t5: abort with seed A5 -> lfsr=%h", lfsr_q);
        // A5 -> 52 -> A9 -> 54 -> 2A
        run_txn("t5b", 4'b1111, 4'b0100, 8'h2A);

        // Reset during GRANT of a requester-2 transaction (pointer was 3).
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        repeat (4) @(negedge clk);
        check("t6_in_grant_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_valid", 32'(rsp_valid), 32'd0);
        check("t6_gnt",   32'(rsp_gnt),   32'd0);
        check("t6_lfsr",  32'(lfsr_q),    32'h01);
        check("t6_busy",  32'(busy),      32'd0);
        $display("txn t6: reset in GRANT -> lfsr=%h valid=%b", lfsr_q, rsp_valid);
        run_txn("t6b", 4'b1010, 4'b0010, 8'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
